// File: rtl/alu_dispatch_pkg.sv
// Shared types for the ALU op dispatcher: opcodes, FSM states, and the start-vector helper.
package alu_dispatch_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_WB    = 2'b11
  } state_e;

  // Functional-unit start vectors are indexed directly by opcode.
  function automatic logic [3:0] op_onehot(input opcode_e op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/alu_dispatch_timer.sv
// WAIT-state watchdog: clears on issue, counts while enabled, saturates at TIMEOUT.
// expired_o is a pure compare on the registered count.
module alu_dispatch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/alu_op_dispatch.sv
// Execute-stage issue: dispatches one op to add/sub/mul/div, waits for done, hands result to writeback.
// Optional ALU_DISPATCH_DIVZERO_CHK_EN short-circuits divide-by-zero to an error writeback.
module alu_op_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_opcode,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd_addr,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [3:0]        unit_start,
  input  logic [3:0]        unit_done,
  output logic [1:0]        out_opcode,
  input  logic [DATA_W-1:0] rd_val,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  state_e            state_q;
  opcode_e           opcode_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, wb_data_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [3:0]        start_q;
  logic              wb_valid_q, wb_err_q;

  logic accept, done_hit, expired, in_div_zero, div_zero;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  // Only the unit that was actually started may complete the op.
  assign done_hit = unit_done[opcode_q];

`ifdef ALU_DISPATCH_DIVZERO_CHK_EN
  assign in_div_zero = (opcode_e'(in_opcode) == OP_DIV) && (in_rs2 == '0);
  assign div_zero    = (opcode_q == OP_DIV) && (op_b_q == '0);
`else
  assign in_div_zero = 1'b0;
  assign div_zero    = 1'b0;
`endif

  alu_dispatch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == S_ISSUE),
    .en_i      (state_q == S_WAIT),
    .expired_o (expired)
  );

  // start_q is loaded on accept so the pulse lines up exactly with the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      opcode_q   <= OP_ADD;
      op_a_q     <= '0;
      op_b_q     <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_err_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      start_q    <= '0;
    end else begin
      start_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            opcode_q  <= opcode_e'(in_opcode);
            op_a_q    <= in_rs1;
            op_b_q    <= in_rs2;
            wb_addr_q <= in_rd_addr;
            start_q   <= in_div_zero ? 4'b0000 : op_onehot(opcode_e'(in_opcode));
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (div_zero) begin
            wb_data_q  <= '1;
            wb_err_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state_q    <= S_WB;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done_hit) begin
            wb_data_q  <= rd_val;
            wb_err_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= S_WB;
          end else if (expired) begin
            wb_data_q  <= '0;
            wb_err_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state_q    <= S_WB;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign unit_start = start_q;
  assign out_opcode = opcode_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign wb_err     = wb_err_q;

endmodule
